// File: rtl/seq_detect_1101_if.sv
// Serial bit-stream bundle between the upstream flop stage and the 1101 detector.
// The master drives EN/DIN and the slave returns DET, the saturating CNT and the debug STATE.
interface seq_detect_1101_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             din;
    logic             det;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       state;

    modport master (
        output en,
        output din,
        input  det,
        input  cnt,
        input  state
    );

    modport slave (
        input  en,
        input  din,
        output det,
        output cnt,
        output state
    );
endinterface

// File: rtl/seq_detect_1101.sv
// Mealy 1101 detector: DET is a registered pulse one clock after the final 1, and CNT saturates.
// EN=0 freezes the FSM and the counter. Define SEQ_DETECT_OVERLAP_EN to reuse the final 1 of a match.
module seq_detect_1101 #(
    parameter int CNT_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    seq_detect_1101_if.slave  bus
);
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_e;

`ifdef SEQ_DETECT_OVERLAP_EN
    localparam state_e MATCH_NEXT = S1;
`else
    localparam state_e MATCH_NEXT = S0;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic             det_q, det_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             match;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S0;
            det_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            det_q   <= det_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        match   = 1'b0;
        if (bus.en) begin
            unique case (state_q)
                S0: state_d = bus.din ? S1 : S0;
                S1: state_d = bus.din ? S2 : S0;
                S2: state_d = bus.din ? S2 : S3;
                S3: begin
                    match   = bus.din;
                    state_d = bus.din ? MATCH_NEXT : S0;
                end
                default: state_d = S0;
            endcase
        end
    end

    // The counter sticks at all-ones; DET still pulses once saturated.
    always_comb begin
        det_d = match;
        cnt_d = cnt_q;
        if (match && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign bus.det   = det_q;
    assign bus.cnt   = cnt_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_seq_detect_1101.sv
// Drives two detectors (CNT_W=8 and CNT_W=2) with one shared stream, checking against a bit-history model.
module tb_seq_detect_1101;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    seq_detect_1101_if #(.CNT_W(8)) bus8 ();
    seq_detect_1101_if #(.CNT_W(2)) bus2 ();

    seq_detect_1101 #(.CNT_W(8)) dut8 (.clk_i(clk), .rst_ni(rst_n), .bus(bus8));
    seq_detect_1101 #(.CNT_W(2)) dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(bus2));

`ifdef SEQ_DETECT_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    // Model: recent accepted bits, unbounded match count, expected DET.
    bit          pat [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    bit          hist[$];
    int unsigned m_cnt = 0;
    logic        m_det = 1'b0;

    function automatic bit tail_is_prefix(int len);
        int n = hist.size();
        if (n < len) return 1'b0;
        for (int i = 0; i < len; i++)
            if (hist[n-len+i] != pat[i]) return 1'b0;
        return 1'b1;
    endfunction

    // State is the longest tail of the live history that is a proper prefix of 1101.
    function automatic int exp_state();
        for (int l = 3; l >= 1; l--)
            if (tail_is_prefix(l)) return l;
        return 0;
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic d);
        if (!r) begin
            hist.delete();
            m_cnt = 0;
            m_det = 1'b0;
        end else if (e) begin
            hist.push_back(d);
            if (hist.size() > 4) void'(hist.pop_front());
            m_det = tail_is_prefix(4);
            if (m_det) begin
                m_cnt++;
                if (!OVERLAP) hist.delete();
            end
        end else begin
            m_det = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic d);
        rst_n     = r;
        bus8.en   = e;
        bus8.din  = d;
        bus2.en   = e;
        bus2.din  = d;
        @(posedge clk);
        model_edge(r, e, d);
        #1;
        chk("state",  32'(bus8.state), 32'(exp_state()));
        chk("det",    32'(bus8.det),   32'(m_det));
        chk("cnt8",   32'(bus8.cnt),   (m_cnt > 255) ? 32'd255 : 32'(m_cnt));
        chk("det2",   32'(bus2.det),   32'(m_det));
        chk("cnt2",   32'(bus2.cnt),   (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
        @(negedge clk);
    endtask

    task automatic bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, 1'b1, v[i]);
    endtask

    initial begin
        rst_n    = 1'b0;
        bus8.en  = 1'b0;
        bus8.din = 1'b0;
        bus2.en  = 1'b0;
        bus2.din = 1'b0;
        @(negedge clk);

        // Reset held with EN=1 and DIN toggling, then one clean pattern.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, i[0]);
            chk("rst_state", 32'(bus8.state), 32'd0);
            chk("rst_det",   32'(bus8.det),   32'd0);
            chk("rst_cnt",   32'(bus8.cnt),   32'd0);
        end
        bits(16'b1101, 4);
        chk("first_det", 32'(bus8.det), 32'd1);
        chk("first_cnt", 32'(bus8.cnt), 32'd1);

        step(1'b0, 1'b0, 1'b0);
        bits(16'b1101101, 7);
        chk("overlap_cnt", 32'(bus8.cnt), OVERLAP ? 32'd2 : 32'd1);

        step(1'b0, 1'b0, 1'b0);
        bits(16'b11110, 5);
        chk("run_state", 32'(bus8.state), 32'd3);
        bits(16'b1, 1);
        chk("run_cnt", 32'(bus8.cnt), 32'd1);

        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("gap_hold", 32'(bus8.state), 32'd2);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("gap_hold3", 32'(bus8.state), 32'd3);
        step(1'b1, 1'b1, 1'b1);
        chk("gap_det", 32'(bus8.det), 32'd1);
        chk("gap_cnt", 32'(bus8.cnt), 32'd1);

        step(1'b0, 1'b0, 1'b0);
        for (int p = 0; p < 5; p++) bits(16'b1101, 4);
        chk("sat_cnt2", 32'(bus2.cnt), 32'd3);
        chk("sat_cnt8", 32'(bus8.cnt), 32'd5);

        step(1'b0, 1'b0, 1'b0);
        bits(16'b110, 3);
        step(1'b0, 1'b1, 1'b1);
        bits(16'b1, 1);
        chk("mid_state", 32'(bus8.state), 32'd1);
        chk("mid_det",   32'(bus8.det),   32'd0);
        chk("mid_cnt",   32'(bus8.cnt),   32'd0);

        // Random traffic, long enough to saturate the narrow counter repeatedly.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seq_detect_1101.md
# seq_detect_1101

Serial pattern detector that sits directly downstream of the asynchronous-reset D flip-flop stage. It consumes that stage's registered Q output as a one-bit serial stream. The block recognises the bit pattern 1101 with a Mealy-style FSM, emits a registered one-cycle detection pulse, and keeps a saturating count of detections for observation in the lab bench.

## Interface
- CNT_W, 8, width of the detection counter (legal range 1 to 16)

- CLK  input  1  system clock; all state updates on the rising edge
- RST_n  input  1  synchronous active-low reset, sampled on the rising edge of CLK
- EN  input  1  sample enable; DIN is consumed only on edges where EN=1
- DIN  input  1  serial data bit, driven by the upstream flip-flop Q
- DET  output  1  registered detection pulse, high for exactly one cycle per match
- CNT  output  CNT_W  number of detections since reset, saturating
- STATE  output  2  current FSM state, for debug (S0=0, S1=1, S2=2, S3=3)

## Operation
- The clock is CLK. Reset is RST_n, synchronous and active-low. Reset has priority over every other input.
- State encoding:
  - S0: no prefix matched.
  - S1: prefix "1" matched.
  - S2: prefix "11" matched.
  - S3: prefix "110" matched.
- Transitions on an edge with EN=1, listed as DIN=0 / DIN=1:
  - S0: S0 / S1.
  - S1: S0 / S2.
  - S2: S3 / S2. The self-loop absorbs runs of 1s.
  - S3: S0 / match. On a match the next state is S1 when overlap is compiled in, otherwise S0.
- A match occurs on an edge where STATE=S3, DIN=1 and EN=1.
  - DET is registered high for the following cycle.
  - CNT increments at that same edge.
- On an edge with EN=0: STATE holds, CNT holds, and DET is registered 0. DIN is ignored.
- CNT saturates at 2^CNT_W-1.
  - Further matches still pulse DET and still advance the FSM.
  - CNT does not wrap.
- DIN is assumed synchronous to CLK, since it is driven by the upstream flip-flop. No input synchroniser is included.

## Timing
- Reset values: STATE=S0, DET=0, CNT=0. These apply on the rising edge where RST_n=0.
- While RST_n=0, the outputs hold their reset values whatever EN and DIN are.
- Latency: DET rises one clock after the edge that samples the final 1 of the pattern. It falls on the next edge unless a second match completes on that edge.
  - Back-to-back matches on consecutive edges are impossible because the pattern is 4 bits long.
  - The minimum DET spacing is 3 cycles with overlap and 4 cycles without.
- CNT and DET change on the same edge. CNT is valid in the same cycle that DET is high.
- Reset mid-pattern: any partial match is discarded. The first bit after reset release is evaluated from S0.
- If RST_n=0 arrives on the same edge as a would-be match, reset wins: DET=0 and CNT=0.

## Configuration
- Macro: SEQ_DETECT_OVERLAP_EN.
- Defined: overlapping detection. After a match the FSM goes to S1, so the final 1 is reused as the first pattern bit. The stream 1101101 yields 2 detections.
- Undefined: non-overlapping detection. After a match the FSM goes to S0. The stream 1101101 yields 1 detection.
- Nothing else changes: ports, counter behaviour and reset behaviour are identical in both builds.

## Test plan
- Reset: hold RST_n=0 for 3 cycles with EN=1 and DIN toggling. Required: STATE=0, DET=0, CNT=0 throughout. After release, DIN=1,1,0,1 gives DET=1 exactly one cycle after the 4th bit and CNT=1.
- Overlap: with EN=1, drive DIN=1,1,0,1,1,0,1.
  - With SEQ_DETECT_OVERLAP_EN: DET pulses after bits 4 and 7, and CNT=2.
  - Without it: one pulse after bit 4, and CNT=1.
- Runs of 1s: with EN=1, drive DIN=1,1,1,1,0,1. Required: STATE sequence 1,2,2,2,3; a single DET after bit 6; CNT=1.
- Enable gaps: drive DIN=1(EN=1), 1(EN=1), 1(EN=0), 0(EN=1), 0(EN=0), 1(EN=1). Required: STATE holds during the EN=0 cycles and DET stays 0 in them; DET=1 after the final bit; CNT=1.
- Saturation: build with CNT_W=2 and drive 5 non-overlapping 1101 patterns. Required: CNT=1,2,3,3,3 and five DET pulses.
- Reset mid-pattern: drive 1,1,0, then RST_n=0 for one edge, then DIN=1. Required: no DET, STATE=S1, CNT=0.
